// File: rtl/tdm_demux.sv
// Time-division demultiplexer: collects a slot-interleaved sample stream into
// per-channel shadow registers and publishes each complete frame on dout at once.

module tdm_demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (wr_en) data_d = wr_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) data_q <= '0;
        else            data_q <= data_d;
    end

    assign data = data_q;

endmodule

module tdm_demux #(
    parameter int CH_NUM = 4,
    parameter int DATA_W = 8,
    localparam int SW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    input  logic                     frame_sync,
    output logic [CH_NUM*DATA_W-1:0] dout,
    output logic                     frame_done,
    output logic                     sync_err,
    output logic [SW-1:0]            slot_idx
);

    localparam logic [SW-1:0] LAST = SW'(CH_NUM - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                     state_q, state_d;
    logic [SW-1:0]              slot_q, slot_d;
    logic [CH_NUM*DATA_W-1:0]   dout_q, dout_d;
    logic                       frame_done_q, frame_done_d;
    logic                       sync_err_q, sync_err_d;

    logic                       shadow_wr;
    logic [SW-1:0]              shadow_sel;
    // The last slot bypasses the shadows and goes straight into dout.
    logic [CH_NUM-2:0][DATA_W-1:0] shadow;

    for (genvar k = 0; k < CH_NUM - 1; k++) begin : g_slot
        tdm_demux_slot #(.DATA_W(DATA_W)) u_slot (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .wr_en     (shadow_wr && (shadow_sel == SW'(k))),
            .wr_data   (din),
            .data      (shadow[k])
        );
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        dout_d       = dout_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        shadow_wr    = 1'b0;
        shadow_sel   = slot_q;
        if (din_valid) begin
            case (state_q)
                IDLE: begin
                    if (frame_sync) begin
                        shadow_wr  = 1'b1;
                        shadow_sel = '0;
                        slot_d     = SW'(1);
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    if (frame_sync) begin
                        // Early sync abandons the partial frame; sample restarts at slot 0.
                        sync_err_d = (slot_q != '0);
                        shadow_wr  = 1'b1;
                        shadow_sel = '0;
                        slot_d     = SW'(1);
                    end else if (slot_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = IDLE;
                    end else if (slot_q == LAST) begin
                        dout_d       = {din, shadow};
                        frame_done_d = 1'b1;
                        slot_d       = '0;
                    end else begin
                        shadow_wr = 1'b1;
                        slot_d    = slot_q + SW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            dout_q       <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout       = dout_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign slot_idx   = slot_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed-vector bench for tdm_demux: CH_NUM=4 main instance plus a CH_NUM=3
// instance exercising the non-power-of-2 slot wrap.

module tb_tdm_demux;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;

    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic [31:0] dout;
    logic        frame_done;
    logic        sync_err;
    logic [1:0]  slot_idx;

    logic [7:0]  din3 = '0;
    logic        din_valid3 = 1'b0;
    logic        frame_sync3 = 1'b0;
    logic [23:0] dout3;
    logic        frame_done3;
    logic        sync_err3;
    logic [1:0]  slot_idx3;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt  = 0;
    int se_cnt  = 0;
    int fd_base, se_base;

    always #5 sys_clk = ~sys_clk;

    tdm_demux #(.CH_NUM(4), .DATA_W(8)) u_dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .slot_idx   (slot_idx)
    );

    tdm_demux #(.CH_NUM(3), .DATA_W(8)) u_dut3 (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .din        (din3),
        .din_valid  (din_valid3),
        .frame_sync (frame_sync3),
        .dout       (dout3),
        .frame_done (frame_done3),
        .sync_err   (sync_err3),
        .slot_idx   (slot_idx3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from a negedge, land on the next negedge and tally pulses.
    task automatic cyc(input logic v, input logic s, input logic [7:0] d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(negedge sys_clk);
        if (frame_done) fd_cnt++;
        if (sync_err)   se_cnt++;
        if (frame_done && sync_err) chk("fd_se_exclusive", 64'd1, 64'd0);
    endtask

    task automatic cyc3(input logic v, input logic s, input logic [7:0] d);
        din_valid3  = v;
        frame_sync3 = s;
        din3        = d;
        @(negedge sys_clk);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_dout", 64'(dout), 64'h0);
        chk("rst_fd", 64'(frame_done), 64'h0);
        chk("rst_se", 64'(sync_err), 64'h0);
        chk("rst_slot", 64'(slot_idx), 64'h0);
        chk("rst_dout3", 64'(dout3), 64'h0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Clean frame
        cyc(1, 1, 8'h11);
        chk("clean_slot1", 64'(slot_idx), 64'd1);
        cyc(1, 0, 8'h22);
        cyc(1, 0, 8'h33);
        chk("clean_slot3", 64'(slot_idx), 64'd3);
        chk("clean_no_fd", 64'(frame_done), 64'd0);
        cyc(1, 0, 8'h44);
        chk("clean_fd", 64'(frame_done), 64'd1);
        chk("clean_dout", 64'(dout), 64'h44332211);
        chk("clean_slot0", 64'(slot_idx), 64'd0);
        cyc(0, 0, 8'h00);
        chk("clean_fd_pulse", 64'(frame_done), 64'd0);
        chk("clean_no_se", 64'(se_cnt), 64'd0);

        // Stalls (frame_sync during stall must be ignored)
        fd_base = fd_cnt;
        cyc(1, 1, 8'h11);
        cyc(1, 0, 8'h22);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 8'hEE);
            chk("stall_slot_hold", 64'(slot_idx), 64'd2);
        end
        cyc(1, 0, 8'h33);
        cyc(1, 0, 8'h44);
        chk("stall_dout", 64'(dout), 64'h44332211);
        cyc(0, 0, 8'h00);
        chk("stall_fd_once", 64'(fd_cnt - fd_base), 64'd1);
        chk("stall_no_se", 64'(se_cnt), 64'd0);

        // Early sync
        fd_base = fd_cnt;
        se_base = se_cnt;
        cyc(1, 1, 8'hA1);
        cyc(1, 0, 8'hA2);
        cyc(1, 1, 8'hB1);
        chk("early_se", 64'(sync_err), 64'd1);
        chk("early_slot", 64'(slot_idx), 64'd1);
        chk("early_dout_hold", 64'(dout), 64'h44332211);
        cyc(1, 0, 8'hB2);
        chk("early_se_pulse", 64'(sync_err), 64'd0);
        cyc(1, 0, 8'hB3);
        chk("early_dout_hold2", 64'(dout), 64'h44332211);
        cyc(1, 0, 8'hB4);
        chk("early_fd", 64'(frame_done), 64'd1);
        chk("early_dout", 64'(dout), 64'hB4B3B2B1);
        chk("early_fd_cnt", 64'(fd_cnt - fd_base), 64'd1);
        chk("early_se_cnt", 64'(se_cnt - se_base), 64'd1);

        // Missing sync, then a dropped unsynced sample in IDLE
        se_base = se_cnt;
        cyc(1, 0, 8'h55);
        chk("miss_se", 64'(sync_err), 64'd1);
        chk("miss_slot", 64'(slot_idx), 64'd0);
        chk("miss_dout", 64'(dout), 64'hB4B3B2B1);
        cyc(1, 0, 8'h5A);
        chk("idle_drop_slot", 64'(slot_idx), 64'd0);
        cyc(1, 1, 8'h66);
        cyc(1, 0, 8'h77);
        cyc(1, 0, 8'h88);
        cyc(1, 0, 8'h99);
        chk("miss_fd", 64'(frame_done), 64'd1);
        chk("miss_dout2", 64'(dout), 64'h99887766);
        chk("miss_se_cnt", 64'(se_cnt - se_base), 64'd1);

        // Back-to-back frames
        fd_base = fd_cnt;
        cyc(1, 1, 8'hC1);
        cyc(1, 0, 8'hC2);
        cyc(1, 0, 8'hC3);
        cyc(1, 0, 8'hC4);
        chk("b2b_fd1", 64'(frame_done), 64'd1);
        chk("b2b_dout1", 64'(dout), 64'hC4C3C2C1);
        cyc(1, 1, 8'hD1);
        chk("b2b_fd_gap", 64'(frame_done), 64'd0);
        cyc(1, 0, 8'hD2);
        cyc(1, 0, 8'hD3);
        chk("b2b_dout_hold", 64'(dout), 64'hC4C3C2C1);
        cyc(1, 0, 8'hD4);
        chk("b2b_fd2", 64'(frame_done), 64'd1);
        chk("b2b_dout2", 64'(dout), 64'hD4D3D2D1);
        chk("b2b_fd_cnt", 64'(fd_cnt - fd_base), 64'd2);

        // Asynchronous reset mid-frame
        fd_base = fd_cnt;
        cyc(1, 1, 8'hE1);
        cyc(1, 0, 8'hE2);
        chk("mid_slot2", 64'(slot_idx), 64'd2);
        din_valid = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", 64'(dout), 64'h0);
        chk("mid_rst_slot", 64'(slot_idx), 64'd0);
        chk("mid_rst_fd", 64'(frame_done), 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cyc(1, 0, 8'hE3);
        cyc(1, 0, 8'hE4);
        chk("mid_no_fd", 64'(fd_cnt - fd_base), 64'd0);
        cyc(1, 1, 8'hF1);
        cyc(1, 0, 8'hF2);
        cyc(1, 0, 8'hF3);
        cyc(1, 0, 8'hF4);
        chk("mid_fd", 64'(frame_done), 64'd1);
        chk("mid_dout", 64'(dout), 64'hF4F3F2F1);
        cyc(0, 0, 8'h00);

        // CH_NUM=3 wrap at 2
        cyc3(1, 1, 8'h11);
        cyc3(1, 0, 8'h22);
        chk("c3_slot2", 64'(slot_idx3), 64'd2);
        cyc3(1, 0, 8'h33);
        chk("c3_fd", 64'(frame_done3), 64'd1);
        chk("c3_dout", 64'(dout3), 64'h332211);
        chk("c3_slot0", 64'(slot_idx3), 64'd0);
        cyc3(1, 1, 8'h44);
        chk("c3_no_se", 64'(sync_err3), 64'd0);
        cyc3(1, 0, 8'h55);
        cyc3(1, 0, 8'h66);
        chk("c3_fd2", 64'(frame_done3), 64'd1);
        chk("c3_dout2", 64'(dout3), 64'h665544);
        cyc3(0, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
